// File: rtl/imem_loader.sv
// Framed byte-stream loader (len, payload, checksum) that owns the CPU program memory and holds the CPU in reset until a good load.
// One byte per cycle when s_valid is high; s_ready decodes from state (high only while a load is in progress).
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_instr,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_cpu_reset;
  logic [7:0]        r_sum;
  logic [8:0]        r_rem;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_load_count;
  logic [TO_W-1:0]   r_idle_cnt;
  logic [7:0]        r_mem [DEPTH];

  logic w_busy;
  logic w_xfer;
  logic w_timeout;

  assign w_busy    = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_xfer    = s_valid && w_busy;
  // Fires on the idle edge that brings the consecutive-idle count up to TIMEOUT.
  assign w_timeout = (TIMEOUT > 0) && w_busy && !s_valid &&
                     (r_idle_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN;
      S_LEN:                 if (w_xfer) w_next = S_LOAD;
      S_LOAD:                if (w_xfer && (r_rem == 9'd1)) w_next = S_CHECK;
      S_CHECK:               if (w_xfer) w_next = (s_data == r_sum) ? S_DONE : S_ERR;
      default:               w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_ERR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cpu_reset  <= 1'b1;
      r_sum        <= '0;
      r_rem        <= '0;
      r_wptr       <= BASE_ADDR;
      r_load_count <= '0;
      r_idle_cnt   <= '0;
    end else begin
      r_state     <= w_next;
      r_cpu_reset <= (w_next != S_DONE);
      if (!w_busy || s_valid) r_idle_cnt <= '0;
      else                    r_idle_cnt <= r_idle_cnt + 1'b1;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_sum        <= '0;
            r_wptr       <= BASE_ADDR;
            r_load_count <= '0;
          end
        end
        S_LEN: begin
          // A length byte of zero encodes a full 256-byte payload.
          if (w_xfer) r_rem <= (s_data == 8'd0) ? 9'd256 : {1'b0, s_data};
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_wptr       <= r_wptr + 1'b1;
            r_sum        <= r_sum + s_data;
            r_load_count <= r_load_count + 1'b1;
            r_rem        <= r_rem - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset so a mid-load reset keeps bytes already written.
  always_ff @(posedge clk) begin
    if ((r_state == S_LOAD) && w_xfer) r_mem[r_wptr] <= s_data;
  end

  assign cpu_instr  = r_mem[cpu_addr];
  assign cpu_reset  = r_cpu_reset;
  assign s_ready    = w_busy;
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);
  assign load_count = r_load_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: instance a (base 00, no timeout) and instance b (base F0, timeout 8) share stimulus.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic [7:0] cpu_addr;
  logic       sel;

  logic       a_s_ready, a_cpu_reset, a_busy, a_done, a_err;
  logic [7:0] a_cpu_instr;
  logic [8:0] a_load_count;
  logic       b_s_ready, b_cpu_reset, b_busy, b_done, b_err;
  logic [7:0] b_cpu_instr;
  logic [8:0] b_load_count;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00), .TIMEOUT(0)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_ready(a_s_ready),
    .s_data(s_data), .cpu_addr(cpu_addr), .cpu_instr(a_cpu_instr), .cpu_reset(a_cpu_reset),
    .busy(a_busy), .done(a_done), .err(a_err), .load_count(a_load_count)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hF0), .TIMEOUT(8)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .s_valid(s_valid), .s_ready(b_s_ready),
    .s_data(s_data), .cpu_addr(cpu_addr), .cpu_instr(b_cpu_instr), .cpu_reset(b_cpu_reset),
    .busy(b_busy), .done(b_done), .err(b_err), .load_count(b_load_count)
  );

  always #5 clk = ~clk;

  // Selected-instance views so one set of tasks serves both DUTs.
  logic       w_rdy, w_crst, w_busy, w_done, w_err;
  logic [7:0] w_instr;
  logic [8:0] w_cnt;
  assign w_rdy   = sel ? b_s_ready    : a_s_ready;
  assign w_crst  = sel ? b_cpu_reset  : a_cpu_reset;
  assign w_busy  = sel ? b_busy       : a_busy;
  assign w_done  = sel ? b_done       : a_done;
  assign w_err   = sel ? b_err        : a_err;
  assign w_instr = sel ? b_cpu_instr  : a_cpu_instr;
  assign w_cnt   = sel ? b_load_count : a_load_count;

  typedef struct {
    logic [7:0]  len;
    logic [23:0] pay;
    logic [7:0]  csum;
    bit          gap;
    bit          exp_done;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } sb_t;

  vec_t vecs[6];
  sb_t  sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge with s_valid low.
  task automatic send_byte(input logic [7:0] d, input bit gap);
    int n;
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!w_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_during_load", 32'(w_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain_sb();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cpu_addr = e.addr;
      #1;
      chk("mem_readback", 32'(w_instr), 32'(e.data));
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input logic [7:0] base, input bit midstart);
    logic [7:0] b;
    start_pulse();
    chk("busy_after_start", 32'(w_busy), 32'd1);
    chk("cnt_after_start", 32'(w_cnt), 32'd0);
    chk("flags_after_start", {30'd0, w_done, w_err}, 32'd0);
    send_byte(v.len, v.gap);
    for (int i = 0; i < int'(v.len); i++) begin
      b = v.pay[23 - 8 * i -: 8];
      sb.push_back('{addr: base + 8'(i), data: b});
      send_byte(b, v.gap);
      if (midstart && i == 0) begin
        start_pulse();
        chk("start_ignored_busy", 32'(w_busy), 32'd1);
        chk("start_ignored_cnt", 32'(w_cnt), 32'd1);
      end
    end
    chk("cpu_reset_before_csum", 32'(w_crst), 32'd1);
    send_byte(v.csum, v.gap);
    chk("done", 32'(w_done), 32'(v.exp_done));
    chk("err", 32'(w_err), 32'(!v.exp_done));
    chk("cpu_reset_after_csum", 32'(w_crst), 32'(!v.exp_done));
    chk("s_ready_after_csum", 32'(w_rdy), 32'd0);
    chk("load_count", 32'(w_cnt), 32'(v.len));
    drain_sb();
  endtask

  initial begin
    vecs[0] = '{len: 8'h03, pay: 24'h123456, csum: 8'h9C, gap: 1'b0, exp_done: 1'b1};
    vecs[1] = '{len: 8'h02, pay: 24'hAABB00, csum: 8'h00, gap: 1'b0, exp_done: 1'b0};
    vecs[2] = '{len: 8'h02, pay: 24'hAABB00, csum: 8'h65, gap: 1'b0, exp_done: 1'b1};
    vecs[3] = '{len: 8'h03, pay: 24'h123456, csum: 8'h9C, gap: 1'b1, exp_done: 1'b1};
    vecs[4] = '{len: 8'h01, pay: 24'h7F0000, csum: 8'h7F, gap: 1'b1, exp_done: 1'b1};
    vecs[5] = '{len: 8'h01, pay: 24'h7F0000, csum: 8'h80, gap: 1'b0, exp_done: 1'b0};

    reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; cpu_addr = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("rst_s_ready", 32'(a_s_ready), 32'd0);
    chk("rst_flags", {29'd0, a_busy, a_done, a_err}, 32'd0);
    chk("rst_load_count", 32'(a_load_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Normal, bad-then-good checksum, gappy stream with ignored start, short frames.
    for (int k = 0; k < 6; k++) run_vec(vecs[k], 8'h00, k == 3);

    // Asynchronous reset between edges in the middle of a payload.
    start_pulse();
    send_byte(8'h03, 1'b0);
    sb.push_back('{addr: 8'h00, data: 8'h21});
    send_byte(8'h21, 1'b0);
    sb.push_back('{addr: 8'h01, data: 8'h22});
    send_byte(8'h22, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_s_ready", 32'(a_s_ready), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_cpu_reset", 32'(a_cpu_reset), 32'd1);
    chk("midrst_load_count", 32'(a_load_count), 32'd0);
    drain_sb();
    reset_n = 1'b1;
    @(negedge clk);

    // 256-byte load at base F0 wrapping through address 00.
    sel = 1'b1;
    start_pulse();
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      sb.push_back('{addr: 8'hF0 + 8'(i), data: 8'(i)});
      send_byte(8'(i), 1'b0);
    end
    send_byte(8'h80, 1'b0);
    chk("full_done", 32'(b_done), 32'd1);
    chk("full_err", 32'(b_err), 32'd0);
    chk("full_load_count", 32'(b_load_count), 32'd256);
    cpu_addr = 8'h00;
    #1;
    chk("wrap_addr00", 32'(b_cpu_instr), 32'h10);
    drain_sb();

    // Idle timeout: err exactly on the eighth idle edge.
    start_pulse();
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (7) @(negedge clk);
    chk("to_err_early", 32'(b_err), 32'd0);
    chk("to_busy_early", 32'(b_busy), 32'd1);
    @(negedge clk);
    chk("to_err", 32'(b_err), 32'd1);
    chk("to_cpu_reset", 32'(b_cpu_reset), 32'd1);
    chk("to_s_ready", 32'(b_s_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
